// File: rtl/inverter_pkg.sv
// rtl/inverter_pkg.sv - shared constants and FSM state type for the reciprocal unit
//
// Purpose: widths, the saturation limit and the FSM state enum, shared by
//          fixed_to_int_inverter, its handshake interface and recip_div_step.
// Ports:   none (package).
// Config:  INVERTER_ROUND_EN is consumed by fixed_to_int_inverter, not here.

package inverter_pkg;

  localparam int IN_W    = 16;    // raw Q1.15 operand width
  localparam int IN_FRAC = 15;    // fractional bits of the operand
  localparam int OUT_W   = 10;    // integer result width
  localparam int X_MAX   = 1023;  // largest representable result

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FINISH
  } state_t;

endpackage

// File: rtl/fixed_to_int_inverter_if.sv
// rtl/fixed_to_int_inverter_if.sv - start/done handshake bundle for the reciprocal unit
//
// Purpose: groups the request/result signals of fixed_to_int_inverter.
// Signals: start (request), y (Q1.15 operand), busy, done (result strobe),
//          x (integer result), sat (clipped to X_MAX), dz (operand was zero).
// Modports: master drives start/y; slave (the unit) drives the results.

interface fixed_to_int_inverter_if;
  import inverter_pkg::*;

  logic             start;
  logic [IN_W-1:0]  y;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] x;
  logic             sat;
  logic             dz;

  modport master (
    output start, y,
    input  busy, done, x, sat, dz
  );

  modport slave (
    input  start, y,
    output busy, done, x, sat, dz
  );

endinterface

// File: rtl/recip_div_step.sv
// rtl/recip_div_step.sv - one combinational restoring-division step
//
// Purpose: shifts the next dividend bit into the partial remainder and
//          subtracts the divisor when it fits.
// Ports:   rem_in  (IN_W+1) partial remainder before the step
//          div_bit (1)      dividend bit for this step, MSB first
//          y       (IN_W)   divisor
//          rem_out (IN_W+1) partial remainder after the step
//          q_bit   (1)      quotient bit produced by this step

module recip_div_step
  import inverter_pkg::*;
(
  input  logic [IN_W:0]   rem_in,
  input  logic            div_bit,
  input  logic [IN_W-1:0] y,
  output logic [IN_W:0]   rem_out,
  output logic            q_bit
);

  logic [IN_W:0] trial;
  logic          unused_rem_msb;

  // The incoming remainder is always below y, so its top bit is zero and
  // the shifted value still fits in IN_W+1 bits.
  assign unused_rem_msb = rem_in[IN_W];
  assign trial          = {rem_in[IN_W-1:0], div_bit};

  assign q_bit   = (trial >= {1'b0, y});
  assign rem_out = q_bit ? (trial - {1'b0, y}) : trial;

endmodule

// File: rtl/fixed_to_int_inverter.sv
// rtl/fixed_to_int_inverter.sv - sequential reciprocal: Q1.15 fraction to 10-bit integer
//
// Purpose: x = 2^15 / Y by one-bit-per-cycle restoring division, with
//          saturation at X_MAX and a divide-by-zero flag. Fixed latency:
//          start accepted at edge k, done high in cycle k+17 -> k+18.
// Ports:   Clk   system clock, rising edge
//          Reset synchronous, active-high
//          bus   slave side of fixed_to_int_inverter_if
//                (start, y in; busy, done, x, sat, dz out)
// Config:  INVERTER_ROUND_EN defined -> round-half-up on the final remainder;
//          undefined -> truncating quotient.

module fixed_to_int_inverter
  import inverter_pkg::*;
(
  input  logic                    Clk,
  input  logic                    Reset,
  fixed_to_int_inverter_if.slave  bus
);

  localparam logic [IN_W-1:0] DIVIDEND = IN_W'(1) << IN_FRAC;

  state_t           state;
  state_t           state_next;

  logic [IN_W-1:0]  operand;
  logic [IN_W-1:0]  dividend;
  logic [IN_W-1:0]  quot;
  logic [IN_W:0]    rem;
  logic [3:0]       cnt;

  logic [IN_W:0]    rem_step;
  logic             q_bit;

  logic [IN_W:0]    q_fin;
  logic [OUT_W-1:0] x_fin;
  logic             sat_fin;
  logic             dz_fin;

  logic [OUT_W-1:0] x_q;
  logic             sat_q;
  logic             dz_q;
  logic             done_q;

  recip_div_step u_step (
    .rem_in  (rem),
    .div_bit (dividend[cnt]),
    .y       (operand),
    .rem_out (rem_step),
    .q_bit   (q_bit)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = DIVIDE;
      DIVIDE:  if (cnt == 4'd0) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Final quotient, widened by one bit so a rounding carry cannot wrap.
  always_comb begin
`ifdef INVERTER_ROUND_EN
    q_fin = {1'b0, quot} + {{IN_W{1'b0}}, ({rem[IN_W-1:0], 1'b0} >= {1'b0, operand})};
`else
    q_fin = {1'b0, quot};
`endif
  end

  // Y == 0 takes precedence: the division ran but its result is meaningless.
  always_comb begin
    x_fin   = q_fin[OUT_W-1:0];
    sat_fin = 1'b0;
    dz_fin  = 1'b0;
    if (operand == '0) begin
      x_fin  = '0;
      dz_fin = 1'b1;
    end else if (q_fin > (IN_W+1)'(X_MAX)) begin
      x_fin   = OUT_W'(X_MAX);
      sat_fin = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      operand  <= '0;
      dividend <= '0;
      quot     <= '0;
      rem      <= '0;
      cnt      <= '0;
      x_q      <= '0;
      sat_q    <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            operand  <= bus.y;
            dividend <= DIVIDEND;
            quot     <= '0;
            rem      <= '0;
            cnt      <= 4'd15;
          end
        end
        DIVIDE: begin
          rem  <= rem_step;
          quot <= {quot[IN_W-2:0], q_bit};
          cnt  <= cnt - 4'd1;
        end
        FINISH: begin
          x_q    <= x_fin;
          sat_q  <= sat_fin;
          dz_q   <= dz_fin;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.x    = x_q;
  assign bus.sat  = sat_q;
  assign bus.dz   = dz_q;

endmodule

// File: tb/tb_fixed_to_int_inverter.sv
// tb/tb_fixed_to_int_inverter.sv - scoreboard bench for fixed_to_int_inverter
//
// Purpose: drives operands through the start/done handshake, predicts each
//          result with an arithmetic model, and checks value and latency
//          when done pulses. Honors INVERTER_ROUND_EN like the design.

module tb_fixed_to_int_inverter;
  import inverter_pkg::*;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  fixed_to_int_inverter_if bus ();

  fixed_to_int_inverter dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int sat;
    int dz;
    int cyc;
    int y;
  } exp_t;

  exp_t sb[$];

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  logic [15:0] dir [12] = '{16'h8000, 16'h4000, 16'h2AAB, 16'd33, 16'd32, 16'd0,
                            16'hFFFF, 16'd1, 16'd31, 16'd34, 16'h7FFF, 16'd1024};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input int yv, input int k);
    exp_t e;
    int q;
    int r;
    e.y   = yv;
    e.cyc = k + 17;
    e.x   = 0;
    e.sat = 0;
    e.dz  = 0;
    if (yv == 0) begin
      e.dz = 1;
    end else begin
      q = 32768 / yv;
      r = 32768 % yv;
`ifdef INVERTER_ROUND_EN
      if (2 * r >= yv) q++;
`endif
      if (q > 1023) begin
        e.x   = 1023;
        e.sat = 1;
      end else begin
        e.x = q;
      end
    end
    return e;
  endfunction

  always @(negedge Clk) begin
    exp_t e;
    if (!Reset && bus.done === 1'b1) begin
      n_done++;
      check_eq("pending_ops", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq($sformatf("x(y=%0d)", e.y), 32'(bus.x), e.x);
        check_eq($sformatf("sat(y=%0d)", e.y), 32'(bus.sat), e.sat);
        check_eq($sformatf("dz(y=%0d)", e.y), 32'(bus.dz), e.dz);
        check_eq($sformatf("latency(y=%0d)", e.y), cyc, e.cyc);
        check_eq("busy_low_with_done", 32'(bus.busy), 0);
      end
    end
  end

  // Call only while the unit is idle (or in its done cycle).
  task automatic run_op(input logic [15:0] yv);
    exp_t e;
    bus.start = 1'b1;
    bus.y     = yv;
    @(posedge Clk);
    #1;
    e = model(int'(yv), cyc);
    sb.push_back(e);
    check_eq("busy_after_start", 32'(bus.busy), 1);
    bus.start = 1'b0;
    bus.y     = 16'($urandom);
  endtask

  task automatic wait_done();
    int n0;
    n0 = n_done;
    for (int i = 0; i < 40 && n_done == n0; i++) begin
      @(negedge Clk);
      #1;
    end
    check_eq("done_count", n_done - n0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got %0d done pulses expected completion", n_done);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.start = 1'b0;
    bus.y     = '0;
    Reset     = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_eq("reset_x", 32'(bus.x), 0);
    check_eq("reset_sat", 32'(bus.sat), 0);
    check_eq("reset_dz", 32'(bus.dz), 0);
    check_eq("reset_done", 32'(bus.done), 0);
    check_eq("reset_busy", 32'(bus.busy), 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Directed values, issued back-to-back in each done cycle.
    for (int i = 0; i < 12; i++) begin
      run_op(dir[i]);
      wait_done();
    end

    for (int i = 0; i < 6; i++) begin
      run_op(16'($urandom_range(0, 65535)));
      wait_done();
    end

    // A start pulse during DIVIDE must be ignored.
    n0 = n_done;
    run_op(16'd100);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    bus.start = 1'b1;
    bus.y     = 16'd7;
    @(negedge Clk);
    bus.start = 1'b0;
    wait_done();
    repeat (25) @(negedge Clk);
    check_eq("single_done", n_done - n0, 1);

    // Reset mid-DIVIDE discards the operation.
    run_op(16'd500);
    repeat (7) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    sb.delete();
    check_eq("midreset_x", 32'(bus.x), 0);
    check_eq("midreset_sat", 32'(bus.sat), 0);
    check_eq("midreset_dz", 32'(bus.dz), 0);
    check_eq("midreset_done", 32'(bus.done), 0);
    check_eq("midreset_busy", 32'(bus.busy), 0);
    Reset = 1'b0;
    n0 = n_done;
    repeat (25) @(negedge Clk);
    check_eq("no_done_after_reset", n_done - n0, 0);

    run_op(16'd3);
    wait_done();
    repeat (3) @(negedge Clk);
    check_eq("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
